// File: rtl/vending_pkg.sv
// rtl/vending_pkg.sv - shared constants, coin codes and coin value lookup for the vending datapath
package vending_pkg;

    localparam int unsigned PRICE_DEFAULT = 100;
    localparam int unsigned MONEY_W       = 8;
    localparam int unsigned CHG_W         = 5;
    localparam int unsigned SALES_W       = 16;

    typedef enum logic [1:0] {
        COIN_5   = 2'b00,
        COIN_10  = 2'b01,
        COIN_25  = 2'b10,
        COIN_100 = 2'b11
    } coin_e;

    // Value in cents of a coin code.
    function automatic logic [MONEY_W-1:0] coin_value(input logic [1:0] code);
        logic [MONEY_W-1:0] val;
        case (code)
            COIN_5:   val = MONEY_W'(5);
            COIN_10:  val = MONEY_W'(10);
            COIN_25:  val = MONEY_W'(25);
            default:  val = MONEY_W'(100);
        endcase
        return val;
    endfunction

endpackage

// File: rtl/vending_if.sv
// rtl/vending_if.sv - controller-facing signal bundle of the vending datapath
interface vending_if;
    import vending_pkg::*;

    logic                 coin_valid;
    logic [1:0]           coin_type;
    logic                 loadc;
    logic                 cen;
    logic                 mge100;
    logic                 ceq0;
    logic                 nickel_out;
    logic                 coin_reject;
    logic [MONEY_W-1:0]   money;
    logic [SALES_W-1:0]   sales_count;

    // Controller / stimulus side.
    modport master (
        output coin_valid, coin_type, loadc, cen,
        input  mge100, ceq0, nickel_out, coin_reject, money, sales_count
    );

    // Datapath side.
    modport slave (
        input  coin_valid, coin_type, loadc, cen,
        output mge100, ceq0, nickel_out, coin_reject, money, sales_count
    );
endinterface

// File: rtl/vending_change_ctr.sv
// rtl/vending_change_ctr.sv - change counter in nickel units with load, decrement and pulse output
module vending_change_ctr
    import vending_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_i,
    input  logic [CHG_W-1:0] load_val_i,
    input  logic             en_i,
    output logic             zero_o,
    output logic             nickel_o
);

    logic [CHG_W-1:0] cnt_q, cnt_d;
    logic             nickel_q, nickel_d;

    // Load wins over decrement; decrement only while non-zero so the counter never underflows.
    always_comb begin
        cnt_d    = cnt_q;
        nickel_d = 1'b0;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d    = cnt_q - CHG_W'(1);
            nickel_d = 1'b1;
        end
    end

    // State and pulse register; reset drops any change still owed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q    <= '0;
            nickel_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            nickel_q <= nickel_d;
        end
    end

    assign zero_o   = (cnt_q == '0);
    assign nickel_o = nickel_q;

endmodule

// File: rtl/vending_datapath.sv
// rtl/vending_datapath.sv - credit accumulator, sales counter and change dispenser
module vending_datapath
    import vending_pkg::*;
#(
    parameter int unsigned PRICE = PRICE_DEFAULT
) (
    input  logic      clk,
    input  logic      reset_n,
    vending_if.slave  bus
);

    localparam logic [MONEY_W-1:0] PRICE_M = MONEY_W'(PRICE);

    logic [MONEY_W-1:0] money_q, money_d;
    logic [SALES_W-1:0] sales_q, sales_d;
    logic               reject_q, reject_d;
    logic               coin_accept;
    logic               enough;
    logic [CHG_W-1:0]   change_val;

    assign enough      = (money_q >= PRICE_M);
    assign coin_accept = bus.coin_valid && !enough && !bus.loadc && !bus.cen;

    // Change owed in nickels; credit is capped at PRICE+95 so this stays within 0..19.
    assign change_val = enough ? CHG_W'((money_q - PRICE_M) / MONEY_W'(5)) : '0;

    // Next credit, sales count and reject flag.
    always_comb begin
        money_d  = money_q;
        sales_d  = sales_q;
        reject_d = bus.coin_valid && !coin_accept;
        if (bus.loadc) begin
            money_d = '0;
            if (sales_q != '1) begin
                sales_d = sales_q + SALES_W'(1);
            end
        end else if (coin_accept) begin
            money_d = money_q + coin_value(bus.coin_type);
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            money_q  <= '0;
            sales_q  <= '0;
            reject_q <= 1'b0;
        end else begin
            money_q  <= money_d;
            sales_q  <= sales_d;
            reject_q <= reject_d;
        end
    end

    vending_change_ctr u_change_ctr (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_i     (bus.loadc),
        .load_val_i (change_val),
        .en_i       (bus.cen),
        .zero_o     (bus.ceq0),
        .nickel_o   (bus.nickel_out)
    );

    assign bus.mge100      = enough;
    assign bus.money       = money_q;
    assign bus.sales_count = sales_q;
    assign bus.coin_reject = reject_q;

endmodule

// File: tb/tb_vending_datapath.sv
// tb/tb_vending_datapath.sv - directed self-checking bench for vending_datapath
module tb_vending_datapath;
    import vending_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   pulses;
    int   zero_at;

    vending_if vif ();

    vending_datapath #(.PRICE(100)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (vif)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic coin(input logic [1:0] code);
        vif.coin_valid = 1'b1;
        vif.coin_type  = code;
        tick();
        vif.coin_valid = 1'b0;
    endtask

    task automatic vend();
        vif.loadc = 1'b1;
        tick();
        vif.loadc = 1'b0;
    endtask

    initial begin
        vif.coin_valid = 1'b0;
        vif.coin_type  = 2'b00;
        vif.loadc      = 1'b0;
        vif.cen        = 1'b0;
        #12;
        check("rst_money", 32'(vif.money), 0);
        check("rst_ceq0", 32'(vif.ceq0), 1);
        check("rst_sales", 32'(vif.sales_count), 0);
        check("rst_nickel", 32'(vif.nickel_out), 0);
        check("rst_reject", 32'(vif.coin_reject), 0);
        check("rst_mge100", 32'(vif.mge100), 0);
        reset_n = 1'b1;

        // Four quarters: first edge after reset already credits.
        coin(COIN_25); check("q1_money", 32'(vif.money), 25);
        coin(COIN_25); check("q2_money", 32'(vif.money), 50);
        check("q2_mge100", 32'(vif.mge100), 0);
        coin(COIN_25); check("q3_money", 32'(vif.money), 75);
        coin(COIN_25); check("q4_money", 32'(vif.money), 100);
        check("q4_mge100", 32'(vif.mge100), 1);
        check("q4_reject", 32'(vif.coin_reject), 0);

        // Coin at full credit is returned.
        coin(COIN_10);
        check("rej10_pulse", 32'(vif.coin_reject), 1);
        check("rej10_money", 32'(vif.money), 100);
        tick();
        check("rej10_clear", 32'(vif.coin_reject), 0);

        // Nickel during cen is returned; cen with zero counter does nothing.
        vif.cen = 1'b1;
        coin(COIN_5);
        check("rej5_pulse", 32'(vif.coin_reject), 1);
        check("rej5_money", 32'(vif.money), 100);
        check("rej5_nickel", 32'(vif.nickel_out), 0);
        vif.cen = 1'b0;

        // Exact price: no change.
        vend();
        check("exact_money", 32'(vif.money), 0);
        check("exact_sales", 32'(vif.sales_count), 1);
        vif.cen = 1'b1;
        check("exact_ceq0", 32'(vif.ceq0), 1);
        tick();
        check("exact_nickel", 32'(vif.nickel_out), 0);
        check("exact_ceq0b", 32'(vif.ceq0), 1);
        vif.cen = 1'b0;

        // 175c -> 15 nickels over 16 enabled cycles.
        coin(COIN_25); coin(COIN_25); coin(COIN_25); coin(COIN_100);
        check("c175_money", 32'(vif.money), 175);
        vend();
        check("c175_money0", 32'(vif.money), 0);
        check("c175_sales", 32'(vif.sales_count), 2);
        check("c175_ceq0", 32'(vif.ceq0), 0);
        pulses = 0;
        zero_at = 0;
        vif.cen = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            pulses += int'(vif.nickel_out);
            if (vif.ceq0 && zero_at == 0) zero_at = i;
        end
        vif.cen = 1'b0;
        check("c175_pulses", 32'(pulses), 15);
        check("c175_zero_at", 32'(zero_at), 15);
        tick();
        check("c175_nick_end", 32'(vif.nickel_out), 0);

        // loadc and cen together: load wins, then full 15 nickels still come out.
        coin(COIN_25); coin(COIN_25); coin(COIN_25); coin(COIN_100);
        vif.loadc = 1'b1;
        vif.cen   = 1'b1;
        tick();
        vif.loadc = 1'b0;
        check("prio_nickel", 32'(vif.nickel_out), 0);
        check("prio_sales", 32'(vif.sales_count), 3);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            pulses += int'(vif.nickel_out);
        end
        vif.cen = 1'b0;
        check("prio_pulses", 32'(pulses), 15);

        // 195c -> 19 nickels; reset after 7.
        coin(COIN_25); coin(COIN_25); coin(COIN_25); coin(COIN_10); coin(COIN_10);
        check("c95_money", 32'(vif.money), 95);
        coin(COIN_100);
        check("c195_money", 32'(vif.money), 195);
        vend();
        pulses = 0;
        vif.cen = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            pulses += int'(vif.nickel_out);
        end
        check("mid_pulses", 32'(pulses), 7);
        check("mid_nick_hi", 32'(vif.nickel_out), 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_nickel", 32'(vif.nickel_out), 0);
        check("arst_ceq0", 32'(vif.ceq0), 1);
        check("arst_sales", 32'(vif.sales_count), 0);
        check("arst_money", 32'(vif.money), 0);
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            pulses += int'(vif.nickel_out);
        end
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            pulses += int'(vif.nickel_out);
        end
        vif.cen = 1'b0;
        check("arst_pulses", 32'(pulses), 0);

        // Saturating sales count: one vend per cycle with loadc held.
        vif.loadc = 1'b1;
        for (int i = 0; i < 65534; i++) begin
            @(posedge clk);
        end
        #1;
        vif.loadc = 1'b0;
        check("sat_fffe", 32'(vif.sales_count), 32'hFFFE);
        vend();
        check("sat_ffff1", 32'(vif.sales_count), 32'hFFFF);
        vend();
        check("sat_ffff2", 32'(vif.sales_count), 32'hFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vending_datapath.md
VENDING_DATAPATH -- requirements
Module: vending_datapath

Interface
REQ-001 The block SHALL have parameter PRICE, default 100, meaning the item price in cents; it SHALL be a multiple of 5 and in the range 5..155.
REQ-002 The block SHALL have the following ports, with clock and reset first; all outputs are registered unless stated otherwise:
- clk  in  1  single system clock, rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- coin_valid  in  1  one-cycle pulse: a coin has been inserted.
- coin_type  in  2  coin code, qualified by coin_valid: 00=5c, 01=10c, 10=25c, 11=100c.
- loadc  in  1  from the controller FSM: transfer credit to the change counter.
- cen  in  1  from the controller FSM: change-dispense enable.
- mge100  out  1  combinational from registers: money >= PRICE.
- ceq0  out  1  combinational from registers: change counter == 0.
- nickel_out  out  1  one-cycle pulse: dispense one 5c coin.
- coin_reject  out  1  one-cycle pulse: the inserted coin was returned, not credited.
- money  out  8  current credit, in cents.
- sales_count  out  16  number of completed vends, saturating.

Function
REQ-003 A coin SHALL be accepted when coin_valid=1, money < PRICE, loadc=0 and cen=0.
- On acceptance, money SHALL become money + the coin value on the next clock edge.
REQ-004 A coin presented while money >= PRICE, loadc=1 or cen=1 SHALL NOT change money.
- coin_reject SHALL be 1 in the cycle after such a coin is presented.
REQ-005 money SHALL never exceed PRICE+95; the 8-bit width holds this without wrap.
REQ-006 mge100 SHALL equal (money >= PRICE) in the same cycle, with no register stage.
REQ-007 On loadc=1, the change counter SHALL load (money - PRICE)/5 in nickel units (5 bits, range 0..19).
- In the same edge, money SHALL be cleared to 0.
- In the same edge, sales_count SHALL increment unless it already equals 16'hFFFF.
REQ-008 If loadc=1 while money < PRICE, the change counter SHALL load 0 and money SHALL be cleared; sales_count SHALL still increment.
REQ-009 ceq0 SHALL equal (change counter == 0) in the same cycle.
REQ-010 When cen=1 and ceq0=0, the change counter SHALL decrement by 1 and nickel_out SHALL be 1 in the following cycle.
REQ-011 When cen=1 and ceq0=0 hold, exactly one nickel_out pulse SHALL be produced per enabled cycle.
REQ-012 cen=1 with ceq0=1 SHALL be a no-op: no nickel_out and no underflow.
REQ-013 If loadc and cen are both 1 in the same cycle, loadc SHALL take priority and no decrement SHALL occur.
REQ-014 Total nickels dispensed per vend SHALL equal the loaded value.
- Cycle timing: loadc in cycle N, then cen from cycle N+1 onward; ceq0 reaches 1 after exactly k enabled cycles for a loaded value of k.

Reset
REQ-015 reset_n=0 SHALL asynchronously force the following, with reset taking precedence over all inputs:
- money=0
- change counter=0 (ceq0=1)
- sales_count=0
- nickel_out=0
- coin_reject=0
REQ-016 Reset asserted mid-dispense SHALL abandon the remaining change with no further nickel_out pulses.
REQ-017 After reset_n deasserts, the first clock edge SHALL already accept a coin.

Structure
REQ-018 Package vending_pkg SHALL hold the following:
- coin code constants, with a value lookup returning 5/10/25/100
- PRICE default
- MONEY_W=8
- CHG_W=5
- SALES_W=16
REQ-019 The change counter (load, decrement, zero flag, nickel_out) SHALL be the single sub-module vending_change_ctr.
- The money accumulator and sales counter SHALL remain in vending_datapath.

Verification
REQ-020 Reset, then insert 4x 25c: money 25, 50, 75, 100; mge100=1 in the same cycle money reaches 100; no coin_reject.
REQ-021 Insert 25c, 25c, 25c, 100c, then loadc: money=175 before loadc, counter loads 15; cen held 16 cycles gives 15 nickel_out pulses, then ceq0=1; money=0; sales_count=1.
REQ-022 Exact 100c, then loadc, then cen: ceq0=1 on the first cen cycle; zero nickel_out pulses.
REQ-023 With money=100, insert 10c, and insert 5c during cen: coin_reject pulses each time; money unchanged.
REQ-024 Load 19 nickels, dispense 7, assert reset_n=0 asynchronously between edges: outputs clear immediately; no further nickel_out pulses.
REQ-025 Preload sales_count=16'hFFFE via 2 vends from a forced state, or by long run: after two loadc pulses it stays 16'hFFFF.
